// File: rtl/socket_frame_arbiter.sv
// ---------------------------------------------------------------------------
// socket_frame_arbiter
//
// Shares one downstream processing module among N_SRC upstream sockets.
// Whole frames of FRAME_LEN words are granted round-robin, so words from
// different sources never interleave downstream. One IDLE bubble cycle
// separates consecutive frames.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   When defined, a frame that stalls for TIMEOUT consecutive BURST cycles
//   is aborted: frame_err pulses for one cycle and arbitration resumes after
//   the aborted source. When undefined, frame_err is tied low and a stalled
//   frame waits indefinitely.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   in_data    in   N_SRC*DATA_WIDTH upstream words, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_dv      in   N_SRC word-available flags
//   in_rd_en   out  N_SRC pop strobes (combinational, at most one set)
//   out_data   out  DATA_WIDTH word forwarded downstream (registered)
//   out_dv     out  out_data valid, one-cycle pulse per word (registered)
//   out_empty  in   downstream can accept a word this cycle
//   out_src    out  index of the currently granted source
//   busy       out  high while a frame is in progress (state BURST)
//   frame_err  out  one-cycle pulse on frame abort (0 without ARB_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module socket_frame_arbiter #(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_SRC*DATA_WIDTH-1:0]   in_data,
    input  logic [N_SRC-1:0]              in_dv,
    output logic [N_SRC-1:0]              in_rd_en,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_dv,
    input  logic                          out_empty,
    output logic [$clog2(N_SRC)-1:0]      out_src,
    output logic                          busy,
    output logic                          frame_err
);

    localparam int SRC_W = $clog2(N_SRC);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    if (N_SRC < 2 || FRAME_LEN < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("socket_frame_arbiter: N_SRC>=2, FRAME_LEN>=1, TIMEOUT>=1 required");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        count_next;
    logic [SRC_W-1:0]        last_grant;
    logic [SRC_W-1:0]        last_grant_next;
    logic [SRC_W-1:0]        grant_next;
    logic [SRC_W-1:0]        rr_pick;
    logic                    any_req;
    logic                    xfer;
    logic                    abort;
    logic [DATA_WIDTH-1:0]   sel_word;

    // Round-robin pick: scan from last_grant+1 upward with wrap. The loop
    // runs from the farthest candidate to the nearest so the nearest
    // requesting source is the last one written and therefore wins.
    always_comb begin
        int               idx;
        logic [SRC_W-1:0] idx_w;
        rr_pick = '0;
        any_req = 1'b0;
        for (int k = N_SRC; k >= 1; k--) begin
            idx   = (int'(last_grant) + k) % N_SRC;
            idx_w = SRC_W'(idx);
            if (in_dv[idx_w]) begin
                rr_pick = idx_w;
                any_req = 1'b1;
            end
        end
    end

    // Word of the granted source; out_src doubles as the grant register.
    assign sel_word = in_data[int'(out_src)*DATA_WIDTH +: DATA_WIDTH];

    // No pop is issued while reset is asserted, even mid-frame.
    assign xfer = (state == BURST) & in_dv[out_src] & out_empty & ~rst;

    assign busy = (state == BURST);

`ifdef ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic [STALL_W-1:0] stall_next;
    logic               stall_hit;

    // Counts consecutive BURST cycles without a transfer.
    assign stall_hit = (state == BURST) & ~xfer &
                       (stall_cnt == STALL_W'(TIMEOUT - 1));

    always_comb begin
        stall_next = '0;
        if (state == BURST && !xfer) begin
            stall_next = stall_cnt + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            frame_err <= 1'b0;
        end else begin
            stall_cnt <= stall_next;
            frame_err <= abort;
        end
    end
`else
    logic stall_hit;
    assign stall_hit = 1'b0;
    assign frame_err = 1'b0;
`endif

    // Next-state and pop-strobe logic.
    always_comb begin
        state_next      = state;
        count_next      = count;
        last_grant_next = last_grant;
        grant_next      = out_src;
        in_rd_en        = '0;
        abort           = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_next = rr_pick;
                    count_next = '0;
                    state_next = BURST;
                end
            end
            BURST: begin
                in_rd_en[out_src] = xfer;
                if (xfer) begin
                    if (count == CNT_W'(FRAME_LEN - 1)) begin
                        last_grant_next = out_src;
                        count_next      = '0;
                        state_next      = IDLE;
                    end else begin
                        count_next = count + CNT_W'(1);
                    end
                end else if (stall_hit) begin
                    // Abandon the partial frame; words already sent stay sent.
                    abort           = 1'b1;
                    last_grant_next = out_src;
                    count_next      = '0;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered state and output word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            last_grant <= SRC_W'(N_SRC - 1);
            out_src    <= '0;
            out_data   <= '0;
            out_dv     <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            last_grant <= last_grant_next;
            out_src    <= grant_next;
            out_dv     <= xfer;
            if (xfer) begin
                out_data <= sel_word;
            end
        end
    end

endmodule

// File: tb/tb_socket_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_socket_frame_arbiter
//
// Directed bench for socket_frame_arbiter with N_SRC=4, DATA_WIDTH=8,
// FRAME_LEN=4, TIMEOUT=8. Source i presents word 8'h10*i + k, where k is a
// 2-bit per-source pointer advanced on each pop and cleared by rst.
// ---------------------------------------------------------------------------
module tb_socket_frame_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int FL = 4;
    localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_dv;
    logic [N-1:0]   in_rd_en;
    logic [W-1:0]   out_data;
    logic           out_dv;
    logic           out_empty;
    logic [1:0]     out_src;
    logic           busy;
    logic           frame_err;

    logic [1:0]     ptr [N];

    int n_cmp = 0;
    int n_err = 0;

    socket_frame_arbiter #(
        .N_SRC(N), .DATA_WIDTH(W), .FRAME_LEN(FL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_dv(in_dv), .in_rd_en(in_rd_en),
        .out_data(out_data), .out_dv(out_dv), .out_empty(out_empty),
        .out_src(out_src), .busy(busy), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream socket model.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) ptr[i] <= 2'd0;
            else if (in_rd_en[i]) ptr[i] <= ptr[i] + 2'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_data[i*W +: W] = 8'(16 * i + int'(ptr[i]));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [7:0] data, input logic [1:0] src);
        chk({tag, "_dv"}, 32'(out_dv), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(data));
        chk({tag, "_src"}, 32'(out_src), 32'(src));
    endtask

    initial begin
        rst       = 1'b1;
        in_dv     = 4'hF;
        out_empty = 1'b1;

        // Reset held three cycles with all sources requesting.
        repeat (3) begin
            tick();
            chk("rst_dv", 32'(out_dv), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_err", 32'(frame_err), 0);
            chk("rst_rd", 32'(in_rd_en), 0);
            chk("rst_src", 32'(out_src), 0);
            chk("rst_data", 32'(out_data), 0);
        end
        rst = 1'b0;
        #1;
        chk("idle_rd", 32'(in_rd_en), 0);

        // Round-robin rotation: 0,1,2,3,0 with one bubble per frame.
        for (int n = 1; n <= 25; n++) begin
            int p;
            int s;
            tick();
            p = (n - 1) % 5;
            s = ((n - 1) / 5) % 4;
            chk("rr_dv", 32'(out_dv), 32'(p != 0));
            if (p != 0) chk("rr_data", 32'(out_data), 32'(16 * s + p - 1));
            chk("rr_src", 32'(out_src), 32'(s));
            chk("rr_busy", 32'(busy), 32'(p != 4));
        end
        in_dv = 4'b0000;
        tick();
        chk("rr_idle_busy", 32'(busy), 0);

        // Backpressure on source 1 with out_empty toggling.
        in_dv = 4'b0010;
        tick();
        chk("bp_grant_src", 32'(out_src), 1);
        chk("bp_grant_busy", 32'(busy), 1);
        for (int j = 0; j < 8; j++) begin
            out_empty = (j % 2 == 0);
            in_dv     = (j == 7) ? 4'b0000 : 4'b0010;
            #1;
            chk("bp_rd", 32'(in_rd_en), (j % 2 == 0) ? 32'h2 : 32'h0);
            tick();
            chk("bp_dv", 32'(out_dv), 32'(j % 2 == 0));
            if (j % 2 == 0) chk("bp_data", 32'(out_data), 32'(8'h10 + j / 2));
            chk("bp_src", 32'(out_src), 1);
        end
        out_empty = 1'b1;

        // Source 2 stalls mid-frame while source 3 requests: no preemption.
        in_dv = 4'b0100;
        tick();
        chk("st_grant_src", 32'(out_src), 2);
        #1;
        chk("st_rd", 32'(in_rd_en), 32'h4);
        tick();
        chk_word("st_w0", 8'h20, 2'd2);
        tick();
        chk_word("st_w1", 8'h21, 2'd2);
        in_dv = 4'b1000;
        repeat (3) begin
            #1;
            chk("st_stall_rd", 32'(in_rd_en), 0);
            tick();
            chk("st_stall_dv", 32'(out_dv), 0);
            chk("st_stall_src", 32'(out_src), 2);
            chk("st_stall_busy", 32'(busy), 1);
        end
        in_dv = 4'b1100;
        #1;
        chk("st_resume_rd", 32'(in_rd_en), 32'h4);
        tick();
        chk_word("st_w2", 8'h22, 2'd2);
        tick();
        chk_word("st_w3", 8'h23, 2'd2);
        chk("st_end_busy", 32'(busy), 0);
        #1;
        chk("st_bubble_rd", 32'(in_rd_en), 0);
        tick();
        chk("st_next_src", 32'(out_src), 3);
        chk("st_next_dv", 32'(out_dv), 0);
        in_dv = 4'b1000;
        for (int w = 0; w < 4; w++) begin
            tick();
            chk_word("s3_w", 8'(8'h30 + w), 2'd3);
        end
        chk("s3_end_busy", 32'(busy), 0);

        // Single requester: source 0 is re-granted after each bubble.
        in_dv = 4'b0001;
        tick();
        chk("one_grant_src", 32'(out_src), 0);
        chk("one_grant_dv", 32'(out_dv), 0);
        for (int w = 0; w < 4; w++) begin
            tick();
            chk_word("one_w", 8'(w), 2'd0);
        end
        tick();
        chk("one_bubble_dv", 32'(out_dv), 0);
        chk("one_regrant_busy", 32'(busy), 1);
        chk("one_regrant_src", 32'(out_src), 0);
        tick();
        chk_word("one_r0", 8'h00, 2'd0);
        tick();
        chk_word("one_r1", 8'h01, 2'd0);

        // Reset mid-frame: no pop during rst, scan restarts at source 0.
        rst = 1'b1;
        #1;
        chk("mid_rst_rd", 32'(in_rd_en), 0);
        tick();
        chk("mid_rst_dv", 32'(out_dv), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_src", 32'(out_src), 0);
        rst   = 1'b0;
        in_dv = 4'b0011;
        #1;
        chk("mid_idle_rd", 32'(in_rd_en), 0);
        tick();
        chk("mid_grant_src", 32'(out_src), 0);
        chk("mid_grant_busy", 32'(busy), 1);
        for (int w = 0; w < 4; w++) begin
            tick();
            chk_word("mid_w", 8'(w), 2'd0);
        end
        tick();
        chk("mid_next_src", 32'(out_src), 1);
        chk("mid_next_dv", 32'(out_dv), 0);

        // Source 1 stalls after one word; aborted only with ARB_TIMEOUT_EN.
        in_dv = 4'b0010;
        tick();
        chk_word("to_w0", 8'h10, 2'd1);
        in_dv = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("to_err", 32'(frame_err), 32'(TO_EN && k == 8));
            chk("to_busy", 32'(busy), 32'(!(TO_EN && k >= 8)));
            chk("to_dv", 32'(out_dv), 0);
        end
        in_dv = 4'b0110;
        tick();
        chk("to_next_src", 32'(out_src), TO_EN ? 32'd2 : 32'd1);
        chk("to_next_dv", 32'(out_dv), TO_EN ? 32'd0 : 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/socket_frame_arbiter.md
Name: socket_frame_arbiter

Overview:
- Shares one downstream processing module among N upstream sockets, one frame at a time.
- Upstream side uses the socket-to-module signalling: data, dv and rd_en per requester.
- Downstream side uses the module-to-socket signalling: data and dv, with backpressure through empty.
- Grants whole frames of FRAME_LEN words, round-robin, so frames from different sources never interleave.

Parameters:
- N_SRC, 4: number of upstream sockets; must be at least 2.
- DATA_WIDTH, 8: word width.
- FRAME_LEN, 16: words per frame; must be at least 1.
- TIMEOUT, 64: stall cycles before a frame is aborted; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- in_data  in  N_SRC*DATA_WIDTH  upstream words; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_dv  in  N_SRC  source i has a word available.
- in_rd_en  out  N_SRC  pops one word from source i; combinational.
- out_data  out  DATA_WIDTH  word forwarded downstream; registered.
- out_dv  out  1  out_data valid; registered, one-cycle pulse per word.
- out_empty  in  1  downstream can accept a word this cycle.
- out_src  out  $clog2(N_SRC)  index of the currently granted source.
- busy  out  1  high while in state BURST.
- frame_err  out  1  one-cycle pulse on frame abort; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, count=0, last_grant=N_SRC-1. All outputs are 0: out_data, out_dv, out_src, busy, frame_err, in_rd_en.
- Reset mid-frame: the remaining words of that frame are abandoned. out_dv is 0 from the next edge. No rd_en is issued during the rst cycle.
- State IDLE:
  - in_rd_en is all 0.
  - If any in_dv bit is set: grant = first index i found scanning (last_grant+1) mod N_SRC upward with wrap, where in_dv[i]=1. Register out_src=grant, count=0, go to BURST.
  - Otherwise stay in IDLE.
  - IDLE always lasts at least one cycle, so there is exactly one bubble cycle between frames.
- State BURST, granted source g:
  - Transfer condition: xfer = in_dv[g] & out_empty.
  - in_rd_en[g] = xfer; all other in_rd_en bits are 0.
  - On xfer: out_data <= word g of in_data, out_dv <= 1. Otherwise out_dv <= 0 and out_data holds its value.
  - Latency: the word popped at edge k appears with out_dv=1 during cycle k+1.
  - On xfer with count==FRAME_LEN-1: last_grant <= g, count <= 0, go to IDLE. Otherwise on xfer: count <= count+1.
  - No xfer (in_dv[g]=0 or out_empty=0): stall. Grant is held and count is unchanged.
  - Requests from other sources never preempt a frame in progress.
- busy = (state==BURST). out_src holds its last value while in IDLE.
- count is $clog2(FRAME_LEN+1) bits wide and never exceeds FRAME_LEN-1.
- FRAME_LEN=1: every transfer returns the block to IDLE.
- Only one requester active: that source is re-granted after each bubble cycle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A stall counter counts consecutive BURST cycles without xfer; it clears on every xfer and on entry to BURST.
  - When it reaches TIMEOUT: pulse frame_err for one cycle, set last_grant <= g, go to IDLE. The partial frame is left as-is downstream.
- Not defined: there is no stall counter, frame_err is constant 0, and a frame stall lasts indefinitely.

Test Plan (N_SRC=4, DATA_WIDTH=8, FRAME_LEN=4 unless stated):
- Reset check: rst held 3 cycles with all in_dv=1 -> out_dv, busy, frame_err, in_rd_en and out_src all 0 throughout; first grant after release is source 0.
- Round-robin rotation: all in_dv=1 constantly, out_empty=1, source i supplies word 8'h10*i+k -> out_data sequence 00..03, 10..13, 20..23, 30..33, then 00..03 again; one out_dv=0 bubble cycle between frames; each burst of 4 out_dv pulses is contiguous.
- Backpressure: source 1 only, out_empty toggling 1,0,1,0 -> in_rd_en[1] pulses only in cycles where out_empty=1; exactly 4 words emitted, in order; out_src=1 throughout.
- Source stall with no preemption: source 2 granted, in_dv[2] drops after 2 words while source 3 requests -> grant stays on 2; after in_dv[2] returns, words 3 and 4 are emitted, then source 3 is granted.
- Reset mid-frame: rst asserted after 2 words of source 0 -> out_dv is 0 next cycle; after release, the arbitration scan restarts from source 0.
- ARB_TIMEOUT_EN with TIMEOUT=8: granted source 1 stalls after 1 word -> frame_err pulses exactly once, 8 cycles after the last xfer; the next frame goes to source 2.
